mintr_controller: RTL and testbench

//  Machine-mode interrupt controller: parametrised successor of the fixed timer/ext/sw block.
//  - Owns mstatus.MIE/MPIE, mie and mip.
//  - Synchronises timer, software, external and NUM_PLAT platform lines.
//  - Selects the highest-priority enabled pending interrupt and holds a req/ack handshake

---
 rtl/mintr_controller_pkg.sv | 37 +++
 rtl/intr_sync.sv | 30 +++
 rtl/mintr_controller.sv | 210 +++++++++++++++++++++
 tb/tb_mintr_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mintr_controller_pkg.sv
// Shared constants and types for the machine-mode interrupt controller.
// CSR addresses, mip/mie bit positions, cause width and FSM state encoding.
package mintr_controller_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam int MSI_BIT   = 3;
    localparam int MTI_BIT   = 7;
    localparam int MEI_BIT   = 11;
    localparam int PLAT_BASE = 16;

    localparam int CAUSE_W = 5;

    typedef logic [CAUSE_W-1:0] cause_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_TRAP = 2'd2
    } intr_state_t;

    typedef struct packed {
        logic mei;
        logic msi;
        logic mti;
    } core_irq_t;

    localparam cause_t CAUSE_MSI = cause_t'(MSI_BIT);
    localparam cause_t CAUSE_MTI = cause_t'(MTI_BIT);
    localparam cause_t CAUSE_MEI = cause_t'(MEI_BIT);

endpackage

// File: rtl/intr_sync.sv
// Vector flop synchroniser with synchronous active-high reset.
// Every bit passes through STAGES flops; output is the last stage.
module intr_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign o_q = stg[STAGES-1];

endmodule

// File: rtl/mintr_controller.sv
// Machine-mode interrupt controller: mstatus.MIE/MPIE, mie, mip and trap handshake.
// Define INTR_PLAT_EDGE_EN for sticky, edge-detected platform mip bits.
module mintr_controller
    import mintr_controller_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_PLAT    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_mtime_irq,
    input  logic                i_msw_irq,
    input  logic                i_mext_irq,
    input  logic [NUM_PLAT-1:0] i_plat_irq,
    input  logic                i_csr_we,
    input  logic [11:0]         i_csr_addr,
    input  logic [XLEN-1:0]     i_csr_wdata,
    output logic [XLEN-1:0]     o_csr_rdata,
    input  logic                i_intr_ack,
    input  logic                i_mret,
    output logic                o_intr_req,
    output logic [XLEN-1:0]     o_mcause,
    output logic                o_mintr_en
);

    localparam int SW = NUM_PLAT + 3;

    logic [SW-1:0]       sync_q;
    logic                s_mei;
    logic                s_msi;
    logic                s_mti;
    logic [NUM_PLAT-1:0] s_plat;

    intr_sync #(
        .WIDTH  (SW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   ({i_mext_irq, i_msw_irq, i_mtime_irq, i_plat_irq}),
        .o_q   (sync_q)
    );

    assign {s_mei, s_msi, s_mti, s_plat} = sync_q;

    intr_state_t         state;
    logic                st_mie;
    logic                st_mpie;
    core_irq_t           mie_core;
    logic [NUM_PLAT-1:0] mie_plat;
    logic [NUM_PLAT-1:0] plat_pend;
    cause_t              cause_q;

    logic sel_mstatus;
    logic sel_mie;
    logic sel_mip;
    logic wr_mstatus;
    logic wr_mie;
    logic wr_mip;

    assign sel_mstatus = (i_csr_addr == CSR_MSTATUS);
    assign sel_mie     = (i_csr_addr == CSR_MIE);
    assign sel_mip     = (i_csr_addr == CSR_MIP);
    assign wr_mstatus  = i_csr_we && sel_mstatus;
    assign wr_mie      = i_csr_we && sel_mie;
    assign wr_mip      = i_csr_we && sel_mip;

`ifdef INTR_PLAT_EDGE_EN
    logic [NUM_PLAT-1:0] plat_prev;
    logic [NUM_PLAT-1:0] plat_rise;
    logic [NUM_PLAT-1:0] plat_clr;

    assign plat_rise = s_plat & ~plat_prev;
    assign plat_clr  = wr_mip ? ~i_csr_wdata[PLAT_BASE +: NUM_PLAT] : '0;

    // A rise in the same cycle as a software clear keeps the bit set
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            plat_prev <= '0;
            plat_pend <= '0;
        end else begin
            plat_prev <= s_plat;
            plat_pend <= (plat_pend & ~plat_clr) | plat_rise;
        end
    end
`else
    assign plat_pend = s_plat;
`endif

    logic unused_csr;
    assign unused_csr = ^{i_csr_wdata, wr_mip};

    logic [XLEN-1:0] mstatus_vec;
    logic [XLEN-1:0] mie_vec;
    logic [XLEN-1:0] mip_vec;

    always_comb begin
        mstatus_vec = '0;
        mstatus_vec[MSTATUS_MIE]  = st_mie;
        mstatus_vec[MSTATUS_MPIE] = st_mpie;

        mie_vec = '0;
        mie_vec[MSI_BIT] = mie_core.msi;
        mie_vec[MTI_BIT] = mie_core.mti;
        mie_vec[MEI_BIT] = mie_core.mei;
        mie_vec[PLAT_BASE +: NUM_PLAT] = mie_plat;

        mip_vec = '0;
        mip_vec[MSI_BIT] = s_msi;
        mip_vec[MTI_BIT] = s_mti;
        mip_vec[MEI_BIT] = s_mei;
        mip_vec[PLAT_BASE +: NUM_PLAT] = plat_pend;
    end

    always_comb begin
        o_csr_rdata = '0;
        unique case (1'b1)
            sel_mstatus: o_csr_rdata = mstatus_vec;
            sel_mie:     o_csr_rdata = mie_vec;
            sel_mip:     o_csr_rdata = mip_vec;
            default:     o_csr_rdata = '0;
        endcase
    end

    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] cause_oh;
    logic            win_hit;
    logic            held;
    cause_t          win;

    assign pend     = mip_vec & mie_vec;
    assign cause_oh = XLEN'(1) << cause_q;
    assign held     = |(pend & cause_oh);
    assign win_hit  = |pend;

    // Later assignments override earlier ones, so lowest priority goes first
    always_comb begin
        win = '0;
        for (int k = NUM_PLAT - 1; k >= 0; k--) begin
            if (pend[PLAT_BASE + k]) begin
                win = cause_t'(PLAT_BASE + k);
            end
        end
        if (pend[MTI_BIT]) win = CAUSE_MTI;
        if (pend[MSI_BIT]) win = CAUSE_MSI;
        if (pend[MEI_BIT]) win = CAUSE_MEI;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            o_intr_req <= 1'b0;
            o_mcause   <= '0;
            cause_q    <= '0;
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_core   <= '0;
            mie_plat   <= '0;
        end else begin
            if (wr_mie) begin
                mie_core.mei <= i_csr_wdata[MEI_BIT];
                mie_core.msi <= i_csr_wdata[MSI_BIT];
                mie_core.mti <= i_csr_wdata[MTI_BIT];
                mie_plat     <= i_csr_wdata[PLAT_BASE +: NUM_PLAT];
            end
            if (wr_mstatus) begin
                st_mie  <= i_csr_wdata[MSTATUS_MIE];
                st_mpie <= i_csr_wdata[MSTATUS_MPIE];
            end
            unique case (state)
                ST_IDLE: begin
                    if (st_mie && win_hit) begin
                        state      <= ST_REQ;
                        o_intr_req <= 1'b1;
                        cause_q    <= win;
                        o_mcause   <= {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, win};
                    end
                end
                ST_REQ: begin
                    if (i_intr_ack) begin
                        state      <= ST_TRAP;
                        o_intr_req <= 1'b0;
                        st_mpie    <= st_mie;
                        st_mie     <= 1'b0;
                    end else if (!held) begin
                        state      <= ST_IDLE;
                        o_intr_req <= 1'b0;
                    end
                end
                ST_TRAP: begin
                    if (i_mret) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    o_intr_req <= 1'b0;
                end
            endcase
            if (i_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
        end
    end

    assign o_mintr_en = st_mie;

endmodule

// File: tb/tb_mintr_controller.sv
// Randomised and directed bench for mintr_controller against a behavioural model.
// Define INTR_PLAT_EDGE_EN to exercise the sticky platform bits as well.
module tb_mintr_controller;

    localparam int XLEN = 32;
    localparam int NP   = 16;
    localparam int SS   = 2;
    localparam logic [31:0] MIE_MASK  = 32'hFFFF_0888;
    localparam logic [31:0] PLAT_MASK = 32'hFFFF_0000;
`ifdef INTR_PLAT_EDGE_EN
    localparam int PLAT_LAT = SS + 1;
`else
    localparam int PLAT_LAT = SS;
`endif

    logic            i_clk;
    logic            i_rst;
    logic            i_mtime_irq;
    logic            i_msw_irq;
    logic            i_mext_irq;
    logic [NP-1:0]   i_plat_irq;
    logic            i_csr_we;
    logic [11:0]     i_csr_addr;
    logic [XLEN-1:0] i_csr_wdata;
    logic [XLEN-1:0] o_csr_rdata;
    logic            i_intr_ack;
    logic            i_mret;
    logic            o_intr_req;
    logic [XLEN-1:0] o_mcause;
    logic            o_mintr_en;

    mintr_controller #(
        .XLEN        (XLEN),
        .NUM_PLAT    (NP),
        .SYNC_STAGES (SS)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_mtime_irq (i_mtime_irq),
        .i_msw_irq   (i_msw_irq),
        .i_mext_irq  (i_mext_irq),
        .i_plat_irq  (i_plat_irq),
        .i_csr_we    (i_csr_we),
        .i_csr_addr  (i_csr_addr),
        .i_csr_wdata (i_csr_wdata),
        .o_csr_rdata (o_csr_rdata),
        .i_intr_ack  (i_intr_ack),
        .i_mret      (i_mret),
        .o_intr_req  (o_intr_req),
        .o_mcause    (o_mcause),
        .o_mintr_en  (o_mintr_en)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: input history in mip layout, newest first
    logic [31:0] dl [SS+1];
    logic [31:0] m_mie;
    logic [31:0] m_sticky;
    logic [31:0] m_mcause;
    logic        m_en;
    logic        m_mpie;
    logic        m_req;
    logic        m_trap;
    int          m_cause;

    function automatic logic [31:0] in_word();
        return ({16'(i_plat_irq), 16'h0}) | (32'(i_mext_irq) << 11)
             | (32'(i_mtime_irq) << 7) | (32'(i_msw_irq) << 3);
    endfunction

    function automatic logic [31:0] mip_now();
`ifdef INTR_PLAT_EDGE_EN
        return (dl[SS-1] & 32'h0000_0888) | m_sticky;
`else
        return dl[SS-1];
`endif
    endfunction

    function automatic int best(input logic [31:0] p);
        if (p[11]) return 11;
        if (p[3]) return 3;
        if (p[7]) return 7;
        for (int k = 16; k < 32; k++) begin
            if (p[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_rdata();
        case (i_csr_addr)
            12'h300: return (32'(m_en) << 3) | (32'(m_mpie) << 7);
            12'h304: return m_mie;
            12'h344: return mip_now();
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] pend, n_mie, n_sticky, edg, clr;
        logic        n_en, n_mpie, n_req, n_trap;
        int          b;
        if (i_rst) begin
            for (int i = 0; i <= SS; i++) dl[i] = '0;
            m_mie = '0; m_sticky = '0; m_mcause = '0;
            m_en = 0; m_mpie = 0; m_req = 0; m_trap = 0; m_cause = 0;
            return;
        end
        pend = mip_now() & m_mie;
        b = best(pend);
        n_mie = m_mie; n_en = m_en; n_mpie = m_mpie;
        n_req = m_req; n_trap = m_trap;
        if (i_csr_we && i_csr_addr == 12'h304) n_mie = i_csr_wdata & MIE_MASK;
        if (i_csr_we && i_csr_addr == 12'h300) begin
            n_en = i_csr_wdata[3];
            n_mpie = i_csr_wdata[7];
        end
        if (!m_req && !m_trap) begin
            if (m_en && b >= 0) begin
                n_req = 1;
                m_cause = b;
                m_mcause = 32'h8000_0000 | 32'(b);
            end
        end else if (m_req) begin
            if (i_intr_ack) begin
                n_req = 0; n_trap = 1;
                n_mpie = m_en; n_en = 0;
            end else if (!pend[m_cause]) begin
                n_req = 0;
            end
        end else if (i_mret) begin
            n_trap = 0;
        end
        if (i_mret) begin
            n_en = m_mpie;
            n_mpie = 1;
        end
        edg = dl[SS-1] & ~dl[SS] & PLAT_MASK;
        clr = (i_csr_we && i_csr_addr == 12'h344) ? (~i_csr_wdata & PLAT_MASK) : '0;
        n_sticky = (m_sticky & ~clr) | edg;
        for (int i = SS; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = in_word();
        m_mie = n_mie; m_en = n_en; m_mpie = n_mpie;
        m_req = n_req; m_trap = n_trap; m_sticky = n_sticky;
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check("req", o_intr_req, m_req);
        check("mcause", o_mcause, m_mcause);
        check("mie_en", o_mintr_en, m_en);
        check("rdata", o_csr_rdata, exp_rdata());
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        i_csr_we = 1; i_csr_addr = a; i_csr_wdata = d;
        tick();
        i_csr_we = 0;
    endtask

    initial begin
        i_rst = 1; i_mtime_irq = 0; i_msw_irq = 0; i_mext_irq = 0;
        i_plat_irq = '0; i_csr_we = 0; i_csr_addr = 12'h304;
        i_csr_wdata = '0; i_intr_ack = 0; i_mret = 0;
        tick(); tick();
        check("rst_req", o_intr_req, 0);
        check("rst_mcause", o_mcause, 0);
        i_rst = 0;

        // External interrupt, full handshake
        csr_wr(12'h300, 32'h8);
        csr_wr(12'h304, 32'h800);
        i_mext_irq = 1;
        tick(); tick();
        check("t1_early", o_intr_req, 0);
        tick();
        check("t1_req", o_intr_req, 1);
        check("t1_cause", o_mcause, 32'h8000_000B);
        i_intr_ack = 1; tick(); i_intr_ack = 0;
        check("t1_mie", o_mintr_en, 0);
        i_csr_addr = 12'h300; #1;
        check("t1_mpie", o_csr_rdata, 32'h80);

        // mret re-enables, request returns, then reset mid-handshake
        i_mret = 1; tick(); i_mret = 0;
        tick();
        check("t5_pre", o_intr_req, 1);
        i_rst = 1; tick(); i_rst = 0;
        i_csr_addr = 12'h304; #1;
        check("t5_req", o_intr_req, 0);
        check("t5_en", o_mintr_en, 0);
        check("t5_mie", o_csr_rdata, 0);
        i_mext_irq = 0;
        tick();

        // Software beats timer; timer follows after mret
        csr_wr(12'h300, 32'h8);
        csr_wr(12'h304, 32'h88);
        i_mtime_irq = 1; i_msw_irq = 1;
        repeat (3) tick();
        check("t2_cause", o_mcause, 32'h8000_0003);
        i_intr_ack = 1; i_msw_irq = 0; tick(); i_intr_ack = 0;
        repeat (3) tick();
        i_mret = 1; tick(); i_mret = 0;
        check("t2_en", o_mintr_en, 1);
        tick();
        check("t2_req", o_intr_req, 1);
        check("t2_cause2", o_mcause, 32'h8000_0007);

        // Withdraw by clearing mie bit 7
        csr_wr(12'h304, 32'h8);
        tick();
        check("t3_req", o_intr_req, 0);
        check("t3_en", o_mintr_en, 1);
        i_mtime_irq = 0;

        // Platform 0 request is not pre-empted by MEI
        csr_wr(12'h304, 32'h1_0800);
        i_plat_irq[0] = 1;
        repeat (PLAT_LAT + 1) tick();
        check("t4_cause", o_mcause, 32'h8000_0010);
        i_mext_irq = 1;
        repeat (4) tick();
        check("t4_hold", o_mcause, 32'h8000_0010);
        check("t4_req", o_intr_req, 1);
        i_intr_ack = 1; tick(); i_intr_ack = 0;
        i_mext_irq = 0; i_plat_irq = '0;
        i_mret = 1; tick(); i_mret = 0;
        csr_wr(12'h304, 32'h0);

`ifdef INTR_PLAT_EDGE_EN
        // Sticky platform bit: pulse, clear, clear racing a rise
        i_csr_addr = 12'h344;
        i_plat_irq[3] = 1; tick(); i_plat_irq[3] = 0;
        repeat (4) tick();
        check("t6_set", o_csr_rdata[19], 1);
        csr_wr(12'h344, 32'h0);
        check("t6_clr", o_csr_rdata[19], 0);
        i_plat_irq[3] = 1;
        repeat (SS) tick();
        csr_wr(12'h344, 32'h0);
        check("t6_race", o_csr_rdata[19], 1);
        i_plat_irq = '0;
        csr_wr(12'h344, 32'h0);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            i_rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) i_mtime_irq = ~i_mtime_irq;
            if ($urandom_range(0, 7) == 0) i_msw_irq = ~i_msw_irq;
            if ($urandom_range(0, 7) == 0) i_mext_irq = ~i_mext_irq;
            if ($urandom_range(0, 3) == 0) i_plat_irq[$urandom_range(0, NP-1)] ^= 1'b1;
            i_csr_we = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: i_csr_addr = 12'h300;
                1: i_csr_addr = 12'h304;
                2: i_csr_addr = 12'h344;
                default: i_csr_addr = 12'($urandom);
            endcase
            i_csr_wdata = $urandom;
            if ($urandom_range(0, 1) == 0) i_csr_wdata[3] = 1'b1;
            i_intr_ack = m_req && ($urandom_range(0, 2) == 0);
            i_mret = !i_intr_ack &&
                     (m_trap ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
